// File: rtl/fb_clear_engine.sv
// Framebuffer clear engine: fills the draw buffer with one RGB565
// colour through a single SRAM arbiter write port.
module fb_clear_engine #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int CNT_W    = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_trigger,
  input  logic [31:0] clear_color,
  input  logic [19:0] fb_base,
  output logic        busy,
  output logic        done,
  output logic        sram_req,
  output logic        sram_we,
  output logic [23:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ack,
  input  logic        sram_ready
);

  localparam int N_XFER = H_PIXELS * V_LINES / 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_XFER - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] REQ  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             req_q, req_d;
  logic [23:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [15:0] pix;
  logic        unused_ok;

  assign pix = {clear_color[23:19], clear_color[15:10], clear_color[7:3]};

  // Read data, alpha and the high base bits never matter for a clear.
  assign unused_ok = ^{sram_rdata, clear_color[31:24],
                       clear_color[18:16], clear_color[9:8],
                       clear_color[2:0], fb_base[19:13]};

  // Next-state: latch a job on trigger, then stream writes until last ack.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (clear_trigger) begin
          busy_d  = 1'b1;
          addr_d  = {fb_base[12:0], 11'b0};
          wdata_d = {pix, pix};
          cnt_d   = '0;
          if (sram_ready) begin
            req_d   = 1'b1;
            state_d = REQ;
          end else begin
            state_d = ARM;
          end
        end
      end
      (state_q == ARM): begin
        if (sram_ready) begin
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      (state_q == REQ): begin
        if (sram_ack) begin
          if (cnt_q == LAST) begin
            req_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d = addr_q + 24'd2;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any clear silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sram_req   = req_q;
  assign sram_we    = req_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_fb_clear_engine.sv
// Randomized bench for fb_clear_engine against a transfer-level
// model of the clear: start address, colour and transfer count.
module tb_fb_clear_engine;

  localparam int H = 64;
  localparam int V = 80;
  localparam int CW = 12;
  localparam int N = H * V / 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_trigger;
  logic [31:0] clear_color;
  logic [19:0] fb_base;
  logic        busy, done;
  logic        sram_req, sram_we;
  logic [23:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ack;
  logic        sram_ready;

  fb_clear_engine #(
    .H_PIXELS(H),
    .V_LINES (V),
    .CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_trigger(clear_trigger),
    .clear_color  (clear_color),
    .fb_base      (fb_base),
    .busy         (busy),
    .done         (done),
    .sram_req     (sram_req),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ack     (sram_ack),
    .sram_ready   (sram_ready)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // model of the clear job
  bit          m_busy, m_req, m_done;
  int          m_k;
  logic [23:0] m_start;
  logic [15:0] m_pix;

  // stimulus controls
  bit          tr;
  bit          ready_v;
  bit          ack_en;
  bit          spur;
  int          maxgap;
  int          gap;
  int          obs_acks;
  logic [23:0] last_addr;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rgb565(logic [31:0] c);
    int r, g, b;
    r = int'((c >> 16) & 32'hFF);
    g = int'((c >> 8) & 32'hFF);
    b = int'(c & 32'hFF);
    return 16'((r / 8) * 2048 + (g / 4) * 32 + b / 8);
  endfunction

  function automatic logic [23:0] exp_addr();
    return 24'(longint'(m_start) + 2 * longint'(m_k));
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_req  = 0;
    m_done = 0;
    m_k    = 0;
    gap    = 0;
  endtask

  // One clock: check outputs, drive inputs, advance the model.
  task automatic cycle();
    @(negedge clk);
    chk("busy", busy, 32'(m_busy));
    chk("done", done, 32'(m_done));
    chk("req", sram_req, 32'(m_req));
    chk("we", sram_we, 32'(m_req));
    if (m_req) begin
      chk("addr", sram_addr, exp_addr());
      chk("wdata", sram_wdata, {m_pix, m_pix});
    end
    if (done) chk("acks", obs_acks, N);
    sram_rdata    = $urandom;
    clear_trigger = tr;
    tr            = 0;
    sram_ready    = ready_v;
    sram_ack      = 1'b0;
    if (spur) begin
      sram_ack = 1'($urandom_range(0, 1));
    end else if (ack_en && m_req) begin
      if (gap == 0) begin
        sram_ack = 1'b1;
        gap = $urandom_range(0, maxgap);
      end else begin
        gap--;
      end
    end
    if (sram_ack && sram_req) begin
      obs_acks++;
      last_addr = sram_addr;
    end
    m_done = 0;
    if (m_busy) begin
      if (!m_req) begin
        m_req = sram_ready;
      end else if (sram_ack) begin
        m_k++;
        if (m_k == N) begin
          m_busy = 0;
          m_req  = 0;
          m_done = 1;
        end
      end
    end else if (clear_trigger) begin
      m_busy   = 1;
      m_req    = sram_ready;
      m_k      = 0;
      m_start  = 24'(longint'(fb_base) * 2048);
      m_pix    = rgb565(clear_color);
      obs_acks = 0;
    end
  endtask

  task automatic run_to_done(int budget, bit disturb);
    int c;
    c = 0;
    while (!m_done && c < budget) begin
      if (disturb && (c % 97) == 50) begin
        tr          = 1;
        clear_color = $urandom;
        fb_base     = 20'($urandom);
      end
      cycle();
      c++;
    end
    chk("done_seen", 32'(m_done), 1);
  endtask

  initial begin
    rst_n         = 1'b0;
    clear_trigger = 1'b0;
    clear_color   = '0;
    fb_base       = '0;
    sram_rdata    = '0;
    sram_ack      = 1'b0;
    sram_ready    = 1'b1;
    tr      = 0;
    ready_v = 1;
    ack_en  = 1;
    spur    = 0;
    maxgap  = 0;
    obs_acks = 0;
    model_reset();
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", sram_req, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // basic clear, ack every cycle
    fb_base     = 20'h00001;
    clear_color = 32'hFFFF8040;
    tr = 1;
    cycle();
    cycle();
    chk("first_addr", sram_addr, 24'h000800);
    chk("first_wdata", sram_wdata, 32'hFC08FC08);
    run_to_done(N + 20, 0);
    cycle();

    // random ack gaps, base 0
    fb_base     = 20'h00000;
    clear_color = $urandom;
    maxgap = 5;
    tr = 1;
    run_to_done(N * 7 + 20, 0);
    chk("last_addr", last_addr, 24'h0013FE);
    cycle();

    // ready low at trigger, raised 10 cycles later
    maxgap = 0;
    ready_v = 0;
    fb_base = 20'h00001;
    clear_color = 32'hFFFF8040;
    tr = 1;
    cycle();
    repeat (10) cycle();
    ready_v = 1;
    run_to_done(N + 40, 0);

    // trigger while done is high starts a fresh clear
    clear_color = 32'h00123456;
    fb_base     = 20'h00042;
    tr = 1;
    cycle();
    run_to_done(N + 20, 1);
    cycle();

    // trigger during done after a disturbed clear
    clear_color = $urandom;
    fb_base     = 20'($urandom);
    maxgap = 2;
    tr = 1;
    cycle();
    run_to_done(N * 4 + 20, 1);
    clear_color = 32'h00FF00FF;
    fb_base     = 20'h00010;
    tr = 1;
    cycle();
    run_to_done(N * 4 + 20, 0);
    cycle();

    // reset after the third ack
    maxgap = 1;
    fb_base = 20'h00003;
    tr = 1;
    for (int i = 0; i < 50 && m_k < 3; i++) cycle();
    ack_en = 0;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_req", sram_req, 0);
    chk("arst_we", sram_we, 0);
    model_reset();
    clear_trigger = 1'b0;
    sram_ack      = 1'b0;
    #4 rst_n = 1'b1;
    ack_en = 1;
    maxgap = 0;
    repeat (3) cycle();
    clear_color = 32'h00804020;
    tr = 1;
    cycle();
    cycle();
    chk("restart_addr", sram_addr, 24'h001800);
    run_to_done(N + 20, 0);
    cycle();

    // spurious acks and random read data while idle
    spur = 1;
    repeat (20) begin
      cycle();
      chk("idle_wdata", sram_wdata, {m_pix, m_pix});
    end
    spur = 0;
    cycle();

    // address wraps past the top of SRAM
    fb_base = 20'hFFFFF;
    clear_color = $urandom;
    tr = 1;
    cycle();
    cycle();
    chk("wrap_first", sram_addr, 24'hFFF800);
    run_to_done(N + 20, 0);
    chk("wrap_last", last_addr, 24'h000BFE);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
